// File: rtl/othello_pkg.sv
// Shared Othello engine definitions: cell encodings, board geometry,
// direction steps and colour helpers used by the validator, controller
// and disc flipper.
package othello_pkg;

  localparam logic [1:0] CELL_EMPTY  = 2'b00;
  localparam logic [1:0] CELL_BLACK  = 2'b01;
  localparam logic [1:0] CELL_WHITE  = 2'b10;
  localparam logic [1:0] CELL_BORDER = 2'b11;

  localparam int BOARD_W     = 10;
  localparam int BOARD_CELLS = 100;

  // Five-bit two's-complement address steps on the 10x10 bordered board.
  localparam logic [4:0] STEP_E  = 5'b00001;
  localparam logic [4:0] STEP_W  = 5'b11111;
  localparam logic [4:0] STEP_S  = 5'b01010;
  localparam logic [4:0] STEP_N  = 5'b10110;
  localparam logic [4:0] STEP_SE = 5'b01011;
  localparam logic [4:0] STEP_NW = 5'b10101;
  localparam logic [4:0] STEP_SW = 5'b01001;
  localparam logic [4:0] STEP_NE = 5'b10111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PLACE,
    S_ADV,
    S_READ,
    S_CHECK,
    S_WRITE,
    S_ERR,
    S_DONE
  } flip_state_t;

  function automatic logic [1:0] own_colour(input logic player);
    return player ? CELL_WHITE : CELL_BLACK;
  endfunction

  function automatic logic [1:0] opp_colour(input logic player);
    return player ? CELL_BLACK : CELL_WHITE;
  endfunction

endpackage

// File: rtl/disc_flipper.sv
// Disc flipper: after a direction has been validated as capturable, walks
// that direction from the move square and recolours each opponent disc in
// board RAM until the mover's own disc is reached.
//
// The first cursor advance is folded into the cycle that accepts start
// (and overlaps S_PLACE), so a run ending on the mover's disc completes
// with done_o in cycle place + 3 + 4*flips. S_ADV is only entered after
// each S_WRITE.
module disc_flipper #(
  parameter int ADDR_W      = 7,
  parameter int BOARD_CELLS = 100,
  parameter int MAX_FLIPS   = 6
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] origin_in,
  input  logic [4:0]        step_in,
  input  logic              player,
  input  logic              place,
  output logic [ADDR_W-1:0] addr_o,
  output logic              wren_o,
  output logic [1:0]        data_o,
  input  logic [1:0]        data_in,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [2:0]        flips_o
);

  import othello_pkg::*;

  localparam logic [ADDR_W-1:0] CELL_LIMIT = ADDR_W'(BOARD_CELLS);
  localparam logic [2:0]        MAX_CNT    = 3'(MAX_FLIPS);

  flip_state_t state;
  flip_state_t state_next;

  logic [ADDR_W-1:0] origin;
  logic [ADDR_W-1:0] step;
  logic [ADDR_W-1:0] cursor;
  logic [1:0]        own;
  logic [1:0]        opp;
  logic [2:0]        count;
  logic              err;

  logic [ADDR_W-1:0] step_ext;
  logic [ADDR_W-1:0] first_cursor;
  logic [ADDR_W-1:0] adv_cursor;

  assign step_ext     = {{(ADDR_W-5){step_in[4]}}, step_in};
  assign first_cursor = origin_in + step_ext;
  assign adv_cursor   = cursor + step;

  // State register with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Run context, cursor, flip count and error flag.
  always_ff @(posedge clock) begin
    if (!reset) begin
      origin <= '0;
      step   <= '0;
      cursor <= '0;
      own    <= CELL_EMPTY;
      opp    <= CELL_EMPTY;
      count  <= '0;
      err    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            origin <= origin_in;
            step   <= step_ext;
            cursor <= first_cursor;
            own    <= own_colour(player);
            opp    <= opp_colour(player);
            count  <= '0;
            err    <= 1'b0;
          end
        end
        S_ADV:   cursor <= adv_cursor;
        S_WRITE: count  <= count + 3'd1;
        S_ERR:   err    <= 1'b1;
        default: ;
      endcase
    end
  end

  // Next-state decision for the walk along the direction.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (step_in == 5'd0) begin
            state_next = S_ERR;
          end else if (place) begin
            state_next = S_PLACE;
          end else if (first_cursor >= CELL_LIMIT) begin
            state_next = S_ERR;
          end else begin
            state_next = S_READ;
          end
        end
      end
      S_PLACE: state_next = (cursor >= CELL_LIMIT) ? S_ERR : S_READ;
      S_ADV:   state_next = (adv_cursor >= CELL_LIMIT) ? S_ERR : S_READ;
      S_READ:  state_next = S_CHECK;
      S_CHECK: begin
        if (data_in == opp) begin
          state_next = (count < MAX_CNT) ? S_WRITE : S_ERR;
        end else if (data_in == own) begin
          state_next = S_DONE;
        end else begin
          state_next = S_ERR;
        end
      end
      S_WRITE: state_next = S_ADV;
      S_ERR:   state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // RAM port and status outputs decoded from the current state.
  always_comb begin
    addr_o = '0;
    wren_o = 1'b0;
    data_o = 2'b00;
    case (state)
      S_PLACE: begin
        addr_o = origin;
        wren_o = 1'b1;
        data_o = own;
      end
      S_READ: begin
        addr_o = cursor;
      end
      S_WRITE: begin
        addr_o = cursor;
        wren_o = 1'b1;
        data_o = own;
      end
      default: ;
    endcase
  end

  assign busy_o  = (state != S_IDLE);
  assign done_o  = (state == S_DONE);
  assign err_o   = err;
  assign flips_o = count;

endmodule

// File: tb/tb_disc_flipper.sv
// Directed self-checking bench for disc_flipper with a synchronous
// one-cycle-latency board RAM model and a write log.
module tb_disc_flipper;

  logic       clock;
  logic       reset;
  logic       start;
  logic [6:0] origin_in;
  logic [4:0] step_in;
  logic       player;
  logic       place;
  logic [6:0] addr_o;
  logic       wren_o;
  logic [1:0] data_o;
  logic [1:0] data_in;
  logic       busy_o;
  logic       done_o;
  logic       err_o;
  logic [2:0] flips_o;

  int checks;
  int failures;

  logic [1:0] mem [128];
  logic [1:0] pre [128];
  logic       load;
  logic [6:0] wr_addr [$];
  logic [1:0] wr_data [$];

  disc_flipper #(
    .ADDR_W(7),
    .BOARD_CELLS(100),
    .MAX_FLIPS(6)
  ) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .origin_in(origin_in),
    .step_in(step_in),
    .player(player),
    .place(place),
    .addr_o(addr_o),
    .wren_o(wren_o),
    .data_o(data_o),
    .data_in(data_in),
    .busy_o(busy_o),
    .done_o(done_o),
    .err_o(err_o),
    .flips_o(flips_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Board RAM: synchronous write, registered read, preload from pre[].
  always @(posedge clock) begin
    if (load) begin
      for (int i = 0; i < 128; i++) mem[i] <= pre[i];
    end else if (wren_o) begin
      mem[addr_o] <= data_o;
      wr_addr.push_back(addr_o);
      wr_data.push_back(data_o);
    end
    data_in <= mem[addr_o];
  end

  task automatic clear_pre();
    for (int i = 0; i < 128; i++) pre[i] = 2'b00;
  endtask

  task automatic load_board();
    load = 1'b1;
    @(posedge clock); #1;
    load = 1'b0;
  endtask

  // Drives one start in cycle 0; optionally pulses a junk start in cycle glitch.
  task automatic run_move(input logic [6:0] o, input logic [4:0] s, input logic p,
                          input logic pl, input int glitch, output int done_cyc,
                          output logic err_v, output logic [2:0] flips_v);
    wr_addr.delete();
    wr_data.delete();
    origin_in = o;
    step_in   = s;
    player    = p;
    place     = pl;
    start     = 1'b1;
    @(posedge clock); #1;
    start    = 1'b0;
    done_cyc = -1;
    err_v    = 1'b0;
    flips_v  = 3'd0;
    for (int n = 1; n <= 80; n++) begin
      if (done_o) begin
        done_cyc = n;
        err_v    = err_o;
        flips_v  = flips_o;
        break;
      end
      if (n == glitch) begin
        start     = 1'b1;
        origin_in = 7'd3;
        step_in   = 5'd1;
        player    = ~p;
        place     = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clock); #1;
    end
    start = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if ({addr_o, wren_o, data_o, busy_o, done_o, err_o, flips_o} !== 16'h0) begin
      failures++;
      $display("[TB] FAIL reset_outputs got addr=%0d wren=%b data=%b busy=%b done=%b err=%b flips=%0d need all zero",
               addr_o, wren_o, data_o, busy_o, done_o, err_o, flips_o);
    end
    reset = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_place_run();
    int dc; logic e; logic [2:0] f;
    logic [6:0] ea [3];
    ea[0] = 7'd44; ea[1] = 7'd45; ea[2] = 7'd46;
    clear_pre();
    pre[45] = 2'b10; pre[46] = 2'b10; pre[47] = 2'b01;
    load_board();
    run_move(7'd44, 5'd1, 1'b0, 1'b1, 0, dc, e, f);
    checks++;
    if (dc !== 12) begin failures++; $display("[TB] FAIL place_done_cycle got %0d need 12", dc); end
    checks++;
    if (f !== 3'd2) begin failures++; $display("[TB] FAIL place_flips got %0d need 2", f); end
    checks++;
    if (e !== 1'b0) begin failures++; $display("[TB] FAIL place_err got %b need 0", e); end
    checks++;
    if (wr_addr.size() != 3) begin
      failures++; $display("[TB] FAIL place_write_count got %0d need 3", wr_addr.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (wr_addr[i] !== ea[i] || wr_data[i] !== 2'b01) begin
          failures++;
          $display("[TB] FAIL place_write%0d got addr=%0d data=%b need addr=%0d data=01", i, wr_addr[i], wr_data[i], ea[i]);
        end
      end
    end
    checks++;
    if (mem[47] !== 2'b01) begin failures++; $display("[TB] FAIL place_anchor got %b need 01", mem[47]); end
  endtask

  task automatic test_diagonal(input int glitch, input string tag);
    int dc; logic e; logic [2:0] f;
    clear_pre();
    pre[44] = 2'b01; pre[33] = 2'b10;
    load_board();
    run_move(7'd55, 5'b10101, 1'b1, 1'b0, glitch, dc, e, f);
    checks++;
    if (dc !== 7) begin failures++; $display("[TB] FAIL %s_done_cycle got %0d need 7", tag, dc); end
    checks++;
    if (f !== 3'd1 || e !== 1'b0) begin
      failures++; $display("[TB] FAIL %s_result got flips=%0d err=%b need flips=1 err=0", tag, f, e);
    end
    checks++;
    if (wr_addr.size() != 1 || wr_addr[0] !== 7'd44 || wr_data[0] !== 2'b10) begin
      failures++;
      $display("[TB] FAIL %s_writes got n=%0d first_addr=%0d first_data=%b need n=1 addr=44 data=10",
               tag, wr_addr.size(), (wr_addr.size() > 0) ? wr_addr[0] : 7'd0, (wr_data.size() > 0) ? wr_data[0] : 2'b00);
    end
    checks++;
    if (mem[3] !== 2'b00) begin failures++; $display("[TB] FAIL %s_ignored_start got mem3=%b need 00", tag, mem[3]); end
  endtask

  task automatic test_border();
    int dc; logic e; logic [2:0] f;
    clear_pre();
    pre[40] = 2'b11;
    load_board();
    run_move(7'd41, 5'b11111, 1'b0, 1'b0, 0, dc, e, f);
    checks++;
    if (dc < 0) begin failures++; $display("[TB] FAIL border_timeout got no done need done"); end
    checks++;
    if (e !== 1'b1 || f !== 3'd0) begin
      failures++; $display("[TB] FAIL border_result got err=%b flips=%0d need err=1 flips=0", e, f);
    end
    checks++;
    if (wr_addr.size() != 0) begin failures++; $display("[TB] FAIL border_writes got %0d need 0", wr_addr.size()); end
  endtask

  task automatic test_step_zero();
    int dc; logic e; logic [2:0] f;
    run_move(7'd44, 5'd0, 1'b0, 1'b1, 0, dc, e, f);
    checks++;
    if (dc !== 2) begin failures++; $display("[TB] FAIL step0_done_cycle got %0d need 2", dc); end
    checks++;
    if (e !== 1'b1) begin failures++; $display("[TB] FAIL step0_err got %b need 1", e); end
    checks++;
    if (wr_addr.size() != 0) begin failures++; $display("[TB] FAIL step0_writes got %0d need 0", wr_addr.size()); end
  endtask

  task automatic test_off_board();
    int dc; logic e; logic [2:0] f;
    clear_pre();
    load_board();
    run_move(7'd95, 5'd10, 1'b1, 1'b0, 0, dc, e, f);
    checks++;
    if (dc < 0 || e !== 1'b1 || wr_addr.size() != 0) begin
      failures++; $display("[TB] FAIL offboard got done=%0d err=%b writes=%0d need err=1 writes=0", dc, e, wr_addr.size());
    end
  endtask

  task automatic test_max_flips();
    int dc; logic e; logic [2:0] f;
    clear_pre();
    for (int i = 12; i <= 17; i++) pre[i] = 2'b10;
    pre[18] = 2'b01;
    load_board();
    run_move(7'd11, 5'd1, 1'b0, 1'b0, 0, dc, e, f);
    checks++;
    if (dc !== 27) begin failures++; $display("[TB] FAIL max_ok_done_cycle got %0d need 27", dc); end
    checks++;
    if (f !== 3'd6 || e !== 1'b0 || wr_addr.size() != 6) begin
      failures++; $display("[TB] FAIL max_ok_result got flips=%0d err=%b writes=%0d need 6 0 6", f, e, wr_addr.size());
    end
    clear_pre();
    for (int i = 12; i <= 18; i++) pre[i] = 2'b10;
    pre[19] = 2'b01;
    load_board();
    run_move(7'd11, 5'd1, 1'b0, 1'b0, 0, dc, e, f);
    checks++;
    if (f !== 3'd6 || e !== 1'b1 || wr_addr.size() != 6) begin
      failures++; $display("[TB] FAIL max_over_result got flips=%0d err=%b writes=%0d need 6 1 6", f, e, wr_addr.size());
    end
    checks++;
    if (mem[18] !== 2'b10) begin failures++; $display("[TB] FAIL max_over_cell18 got %b need 10", mem[18]); end
  endtask

  task automatic test_reset_mid_write();
    int seen;
    clear_pre();
    pre[23] = 2'b01; pre[24] = 2'b01; pre[25] = 2'b01; pre[26] = 2'b10;
    load_board();
    origin_in = 7'd22; step_in = 5'd1; player = 1'b1; place = 1'b0; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    seen = 0;
    for (int n = 1; n <= 20; n++) begin
      if (wren_o) begin seen = 1; break; end
      @(posedge clock); #1;
    end
    checks++;
    if (seen != 1) begin failures++; $display("[TB] FAIL midreset_no_write got none need write"); end
    reset = 1'b0;
    @(posedge clock); #1;
    checks++;
    if ({addr_o, wren_o, data_o, busy_o, done_o, err_o, flips_o} !== 16'h0) begin
      failures++;
      $display("[TB] FAIL midreset_outputs got addr=%0d wren=%b data=%b busy=%b done=%b err=%b flips=%0d need all zero",
               addr_o, wren_o, data_o, busy_o, done_o, err_o, flips_o);
    end
    checks++;
    if (mem[23] !== 2'b10 || mem[24] !== 2'b01) begin
      failures++; $display("[TB] FAIL midreset_ram got c23=%b c24=%b need 10 01", mem[23], mem[24]);
    end
    reset = 1'b1;
    @(posedge clock); #1;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    load      = 1'b0;
    start     = 1'b0;
    origin_in = '0;
    step_in   = '0;
    player    = 1'b0;
    place     = 1'b0;
    clear_pre();
    test_reset();
    load_board();
    test_place_run();
    test_diagonal(0, "diag");
    test_border();
    test_step_zero();
    test_off_board();
    test_max_flips();
    test_reset_mid_write();
    test_diagonal(3, "busy_start");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
